// File: rtl/sw_port_rx.sv
// sw_port_rx: store-and-forward packet receiver with length check, drop counter and ready/valid byte streaming
module sw_port_rx #(
  parameter int MAX_PAYLOAD = 16,
  parameter int BUF_DEPTH   = 64,
  parameter int PKT_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       sw_enable_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       read_out,
  output logic [7:0] drop_cnt
);
  localparam int AW     = $clog2(BUF_DEPTH);
  localparam int QW     = $clog2(PKT_DEPTH);
  localparam int MAXLEN = MAX_PAYLOAD + 2;
  localparam int LW     = $clog2(MAXLEN + 1) > 5 ? $clog2(MAXLEN + 1) : 5;
  localparam logic [LW-1:0] MAXL  = LW'(MAXLEN);
  localparam logic [QW:0]   QFULL = (QW+1)'(PKT_DEPTH);
  typedef enum logic [1:0] {IDLE, RECV, DROP} rx_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_t;
  rx_t rx_st, rx_nx;
  tx_t tx_st, tx_nx;
  logic [7:0]    mem [BUF_DEPTH];
  logic [LW-1:0] q_len [PKT_DEPTH];
  logic [AW:0]   wr_spec, wr_com, rd_ptr, occ;
  logic [QW-1:0] q_wr, q_rd;
  logic [QW:0]   q_cnt;
  logic [LW-1:0] rx_cnt, tx_idx;
  logic          buf_full, q_full, wr_en, commit, drop, beat, pop;
  // pointers carry one extra wrap bit so occupancy of BUF_DEPTH reads as full
  assign occ      = wr_spec - rd_ptr;
  assign buf_full = occ[AW];
  assign q_full   = q_cnt == QFULL;
  always_ff @(posedge clk or posedge rst)
    if (rst) rx_st <= IDLE;
    else rx_st <= rx_nx;
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:    if (sw_enable_in) rx_nx = buf_full ? DROP : RECV;
      RECV:    rx_nx = !sw_enable_in ? IDLE : (buf_full || rx_cnt == MAXL) ? DROP : RECV;
      default: if (!sw_enable_in) rx_nx = IDLE;
    endcase
  end
  always_comb begin
    wr_en  = sw_enable_in && rx_st != DROP && rx_nx != DROP;
    commit = rx_st == RECV && !sw_enable_in && rx_cnt >= LW'(3) && !q_full;
    drop   = (rx_st != DROP && rx_nx == DROP) || (rx_st == RECV && !sw_enable_in && !commit);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_cnt   <= '0;
      wr_spec  <= '0;
      wr_com   <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) rx_cnt <= rx_st == IDLE ? LW'(1) : rx_cnt + LW'(1);
      if (drop) wr_spec <= wr_com;
      else if (wr_en) wr_spec <= wr_spec + 1'b1;
      if (commit) wr_com <= wr_spec;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_spec[AW-1:0]] <= data_in;
    if (commit) q_len[q_wr] <= rx_cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      if (commit) q_wr <= q_wr + 1'b1;
      if (pop) q_rd <= q_rd + 1'b1;
      q_cnt <= q_cnt + {{QW{1'b0}}, commit} - {{QW{1'b0}}, pop};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) tx_st <= TX_IDLE;
    else tx_st <= tx_nx;
  always_comb
    tx_nx = tx_st == TX_IDLE ? (q_cnt != '0 ? TX_SEND : TX_IDLE) : (pop ? TX_IDLE : TX_SEND);
  always_comb begin
    out_valid = tx_st == TX_SEND;
    read_out  = out_valid;
    out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
    out_sop   = out_valid && tx_idx == '0;
    out_eop   = out_valid && tx_idx == q_len[q_rd] - LW'(1);
    beat      = out_valid && out_ready;
    pop       = beat && out_eop;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      tx_idx <= '0;
    end else if (beat) begin
      rd_ptr <= rd_ptr + 1'b1;
      tx_idx <= out_eop ? '0 : tx_idx + LW'(1);
    end
endmodule

// File: tb/tb_sw_port_rx.sv
// tb_sw_port_rx: randomized and directed checks of sw_port_rx against a packet-level scoreboard
module tb_sw_port_rx;
  localparam int MAXLEN = 18;
  localparam int PKTD   = 2;
  logic       clk = 0, rst = 1;
  logic [7:0] data_in = 0;
  logic       sw_enable_in = 0, out_ready = 0;
  logic [7:0] out_data, drop_cnt;
  logic       out_valid, out_sop, out_eop, read_out;
  int         n_tests = 0, n_fail = 0;
  int         acc = 0, pops = 0, drops = 0;
  logic [9:0] exp_q [$];
  bit         rand_rdy = 0, stall = 0;
  logic [9:0] prev;
  sw_port_rx #(.MAX_PAYLOAD(16), .BUF_DEPTH(64), .PKT_DEPTH(PKTD)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sw_enable_in(sw_enable_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .read_out(read_out), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #2;
    if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
  end
  // scoreboard: every transferred beat must match the next expected {sop,eop,data}
  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      n_tests++;
      if (read_out !== out_valid) begin
        n_fail++;
        $display("FAIL read_out: got %b, required %b", read_out, out_valid);
      end
      if (stall) begin
        n_tests++;
        if ({out_sop, out_eop, out_data} !== prev) begin
          n_fail++;
          $display("FAIL stall_stable: got %h, required %h", {out_sop, out_eop, out_data}, prev);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected beat %h, required none", out_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({out_sop, out_eop, out_data} !== e) begin
            n_fail++;
            $display("FAIL beat: got sop/eop/data %h, required %h", {out_sop, out_eop, out_data}, e);
          end
          if (e[8]) pops++;
        end
      end
      stall = out_valid && !out_ready;
      prev  = {out_sop, out_eop, out_data};
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // drives one frame; decision is taken with the state seen just before the end edge
  task automatic send_frame(input int len, input logic [7:0] da, input logic [7:0] sa, input bit fixed);
    logic [7:0] b [$];
    logic [7:0] v;
    for (int i = 0; i < len; i++) begin
      v = i == 0 ? da : i == 1 ? sa : fixed ? 8'(8'hA1 + i - 2) : 8'($urandom);
      b.push_back(v);
      sw_enable_in = 1;
      data_in = v;
      tick();
    end
    sw_enable_in = 0;
    data_in = 8'($urandom);
    if (len >= 3 && len <= MAXLEN && acc - pops < PKTD) begin
      acc++;
      for (int i = 0; i < len; i++) exp_q.push_back({i == 0, i == len - 1, b[i]});
    end else drops++;
  endtask
  task automatic drain(input string name);
    int t = 0;
    rand_rdy = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      tick();
      t++;
    end
    n_tests++;
    if (exp_q.size() != 0 || out_valid) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats left valid=%b, required 0 left", name, exp_q.size(), out_valid);
    end
    n_tests++;
    if (drop_cnt !== 8'(drops)) begin
      n_fail++;
      $display("FAIL %s_drop_cnt: got %0d, required %0d", name, drop_cnt, drops);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    tick();
    tick();
    n_tests++;
    if ({out_valid, out_sop, out_eop, read_out, out_data, drop_cnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {out_valid, out_sop, out_eop, read_out, out_data, drop_cnt});
    end
    rst = 0;
    tick();
  endtask
  task automatic test_basic;
    logic [7:0] exp_b [4] = '{8'h05, 8'h02, 8'hA1, 8'hA2};
    out_ready = 1;
    send_frame(4, 8'h05, 8'h02, 1);
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: out_valid %b at end edge, required 0", out_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({out_valid, read_out, out_sop, out_eop, out_data} !== {1'b1, 1'b1, i == 0, i == 3, exp_b[i]}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got v/r/sop/eop/data %b%b%b%b %h, required 11%b%b %h",
                 i, out_valid, read_out, out_sop, out_eop, out_data, i == 0, i == 3, exp_b[i]);
      end
      tick();
    end
    n_tests++;
    if (read_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_end: read_out %b, required 0", read_out);
    end
    drain("basic");
  endtask
  task automatic test_bad_len;
    bit seen = 0;
    out_ready = 1;
    send_frame(2, 8'h11, 8'h22, 0);
    tick();
    send_frame(19, 8'h33, 8'h44, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL bad_len_output: out_valid seen 1, required 0");
    end
    drain("bad_len");
  endtask
  task automatic test_queue_full;
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      send_frame(18, 8'(8'h10 + k), 8'h77, 0);
      tick();
    end
    tick();
    n_tests++;
    if ({out_valid, out_sop, out_data} !== {2'b11, 8'h10}) begin
      n_fail++;
      $display("FAIL qfull_head: got v/sop/data %b%b %h, required 11 10", out_valid, out_sop, out_data);
    end
    n_tests++;
    if (drop_cnt !== 8'(drops)) begin
      n_fail++;
      $display("FAIL qfull_drop: got %0d, required %0d", drop_cnt, drops);
    end
    drain("qfull");
  endtask
  task automatic test_stall;
    bit pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    logic [7:0] d;
    out_ready = 1;
    send_frame(6, 8'h5A, 8'hA5, 0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      out_ready = pat[i];
      d = out_data;
      tick();
      if (!pat[i]) begin
        n_tests++;
        if (out_data !== d) begin
          n_fail++;
          $display("FAIL stall_data%0d: got %h, required %h", i, out_data, d);
        end
      end
    end
    drain("stall");
  endtask
  task automatic test_back_to_back;
    out_ready = 1;
    send_frame(4, 8'h66, 8'h01, 0);
    tick();
    tick();
    send_frame(3, 8'h3C, 8'h02, 0);
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: out_valid %b, required 0", out_valid);
    end
    tick();
    n_tests++;
    if ({out_valid, out_sop, out_data} !== {2'b11, 8'h3C}) begin
      n_fail++;
      $display("FAIL b2b_sop: got v/sop/data %b%b %h, required 11 3c", out_valid, out_sop, out_data);
    end
    drain("b2b");
  endtask
  task automatic test_reset_mid;
    out_ready = 0;
    send_frame(4, 8'h44, 8'h55, 0);
    tick();
    tick();
    sw_enable_in = 1;
    data_in = 8'h91;
    tick();
    data_in = 8'h92;
    tick();
    data_in = 8'h93;
    #2;
    rst = 1;
    #1;
    n_tests++;
    if ({out_valid, out_sop, out_eop, read_out, out_data, drop_cnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h, required 0", {out_valid, out_sop, out_eop, read_out, out_data, drop_cnt});
    end
    exp_q.delete();
    acc = 0;
    pops = 0;
    drops = 0;
    sw_enable_in = 0;
    tick();
    tick();
    rst = 0;
    tick();
    out_ready = 1;
    send_frame(3, 8'hC3, 8'h3C, 0);
    drain("rst_mid");
  endtask
  task automatic test_random;
    rand_rdy = 1;
    for (int k = 0; k < 30; k++) begin
      send_frame($urandom_range(1, 21), 8'($urandom), 8'($urandom), 0);
      repeat ($urandom_range(1, 3)) tick();
    end
    drain("random");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_queue_full();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
